sopc_run_ctrl: RTL and testbench

Synthesizable run controller that sits between the board reset/clock and the minimal OpenMIPS SOPC. It turns an asynchronous active-low board reset into a synchronized, stretched, active-high CPU reset. It then bounds the run length in clock cycles and freezes the core when the run limit or a halt request is reached. This is the on-chip counterpart of the bench's reset-release and stop-after-N sequencing, so the same sequence can be run on hardware.

---
 rtl/sopc_run_ctrl_pkg.sv | 16 +
 rtl/sopc_run_ctrl_rst_sync2.sv | 24 ++
 rtl/sopc_run_ctrl.sv | 122 ++++++++++++
 tb/tb_sopc_run_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/sopc_run_ctrl_pkg.sv
// Shared encodings for the SOPC run controller: sequencing states and
// the active levels of the CPU reset and clock-enable.
package sopc_run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } run_state_e;

    localparam logic RstEnable   = 1'b1;
    localparam logic RstDisable  = 1'b0;
    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;

endpackage

// File: rtl/sopc_run_ctrl_rst_sync2.sv
// Two-flop reset synchronizer: assertion is asynchronous, release is
// aligned to clk after two rising edges.
module rst_sync2 (
    input  logic clk,
    input  logic rst_n,
    output logic rst_sync
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= 1'b1;
            sync_q <= meta_q;
        end
    end

    assign rst_sync = sync_q;

endmodule

// File: rtl/sopc_run_ctrl.sv
// Run controller for the OpenMIPS SOPC: stretches a synchronized reset,
// runs the core for a bounded number of cycles, then freezes it.
//
// state   | meaning
// ST_HOLD | cpu held in reset; hold_cnt advances once rst_sync is up
// ST_RUN  | cpu clock-enabled; cycle_cnt counts (saturating)
// ST_DONE | cpu frozen; done and cycle_cnt held until rst or sw_rst_req
module sopc_run_ctrl
    import sopc_run_ctrl_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned RUN_CYCLES  = 50,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sw_rst_req,
    input  logic             halt_req,
    output logic             cpu_rst,
    output logic             cpu_ce,
    output logic             done,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LAST    = CNT_W'(RUN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam bit               RUN_LIMITED = (RUN_CYCLES != 0);

    logic             rst_sync;
    run_state_e       state_q, state_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic             cpu_rst_q, cpu_rst_d;
    logic             cpu_ce_q, cpu_ce_d;
    logic             done_q, done_d;

    rst_sync2 u_rst_sync2 (
        .clk      (clk),
        .rst_n    (rst),
        .rst_sync (rst_sync)
    );

    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        cpu_rst_d   = cpu_rst_q;
        cpu_ce_d    = cpu_ce_q;
        done_d      = done_q;

        // Soft reset leaves the synchronizer alone, so the hold restarts at once.
        if (sw_rst_req) begin
            state_d     = ST_HOLD;
            hold_cnt_d  = '0;
            cycle_cnt_d = '0;
            done_d      = 1'b0;
            cpu_rst_d   = RstEnable;
            cpu_ce_d    = ChipDisable;
        end else begin
            unique case (state_q)
                ST_HOLD: begin
                    if (rst_sync) begin
                        if (hold_cnt_q == HOLD_LAST) begin
                            state_d     = ST_RUN;
                            hold_cnt_d  = '0;
                            cycle_cnt_d = '0;
                            cpu_rst_d   = RstDisable;
                            cpu_ce_d    = ChipEnable;
                        end else begin
                            hold_cnt_d = hold_cnt_q + CNT_ONE;
                        end
                    end
                end
                ST_RUN: begin
                    if (cycle_cnt_q != '1) begin
                        cycle_cnt_d = cycle_cnt_q + CNT_ONE;
                    end
                    if (halt_req || (RUN_LIMITED && (cycle_cnt_q == RUN_LAST))) begin
                        state_d  = ST_DONE;
                        cpu_ce_d = ChipDisable;
                        done_d   = 1'b1;
                    end
                end
                ST_DONE: begin
                end
                default: begin
                    state_d     = ST_HOLD;
                    hold_cnt_d  = '0;
                    cycle_cnt_d = '0;
                    done_d      = 1'b0;
                    cpu_rst_d   = RstEnable;
                    cpu_ce_d    = ChipDisable;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_HOLD;
            hold_cnt_q  <= '0;
            cycle_cnt_q <= '0;
            cpu_rst_q   <= RstEnable;
            cpu_ce_q    <= ChipDisable;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
            cpu_rst_q   <= cpu_rst_d;
            cpu_ce_q    <= cpu_ce_d;
            done_q      <= done_d;
        end
    end

    assign cpu_rst   = cpu_rst_q;
    assign cpu_ce    = cpu_ce_q;
    assign done      = done_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_sopc_run_ctrl.sv
// Scoreboard bench for sopc_run_ctrl: a default instance (hold 4, run 50)
// and a saturating instance (hold 1, unlimited run, 4-bit counter).
module tb_sopc_run_ctrl;

    localparam int    P_HOLD = 0;
    localparam int    P_RUN  = 1;
    localparam int    P_DONE = 2;
    localparam longint MAXA  = 64'h0000_0000_FFFF_FFFF;
    localparam longint MAXB  = 15;

    typedef struct {
        int phase;
        int hold;
        int run;
        int rel;
    } mdl_t;

    typedef struct {
        logic   r;
        logic   c;
        logic   d;
        longint cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sw_a = 1'b0, halt_a = 1'b0, sw_b = 1'b0, halt_b = 1'b0;
    logic        cpu_rst_a, cpu_ce_a, done_a;
    logic [31:0] cnt_a;
    logic        cpu_rst_b, cpu_ce_b, done_b;
    logic [3:0]  cnt_b;

    int   tests = 0;
    int   fails = 0;
    mdl_t ma, mb;
    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;

    sopc_run_ctrl #(.HOLD_CYCLES(4), .RUN_CYCLES(50), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .sw_rst_req(sw_a), .halt_req(halt_a),
        .cpu_rst(cpu_rst_a), .cpu_ce(cpu_ce_a), .done(done_a), .cycle_cnt(cnt_a)
    );

    sopc_run_ctrl #(.HOLD_CYCLES(1), .RUN_CYCLES(0), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .sw_rst_req(sw_b), .halt_req(halt_b),
        .cpu_rst(cpu_rst_b), .cpu_ce(cpu_ce_b), .done(done_b), .cycle_cnt(cnt_b)
    );

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.phase = P_HOLD;
        m.hold  = 0;
        m.run   = 0;
        m.rel   = 0;
        return m;
    endfunction

    // One clock edge with rst released: rel counts edges since release, the
    // synchronizer is ready once two have passed.
    function automatic mdl_t mdl_edge(mdl_t m, logic sw, logic halt, int hc, int rc);
        mdl_t n;
        n = m;
        if (sw) begin
            n.phase = P_HOLD;
            n.hold  = 0;
            n.run   = 0;
        end else if (m.phase == P_HOLD) begin
            if (m.rel >= 2) begin
                n.hold = m.hold + 1;
                if (n.hold == hc) begin
                    n.phase = P_RUN;
                    n.run   = 0;
                end
            end
        end else if (m.phase == P_RUN) begin
            n.run = m.run + 1;
            if (halt || (rc != 0 && n.run == rc)) n.phase = P_DONE;
        end
        if (m.rel < 1000) n.rel = m.rel + 1;
        return n;
    endfunction

    function automatic exp_t exp_of(mdl_t m, longint maxcnt);
        exp_t e;
        e.r   = (m.phase == P_HOLD);
        e.c   = (m.phase == P_RUN);
        e.d   = (m.phase == P_DONE);
        e.cnt = (longint'(m.run) > maxcnt) ? maxcnt : longint'(m.run);
        return e;
    endfunction

    task automatic chk(input string nm, input exp_t e, input logic r, input logic c,
                       input logic d, input longint cnt);
        tests++;
        if (r !== e.r || c !== e.c || d !== e.d || cnt != e.cnt) begin
            fails++;
            $display("FAIL %s @%0t: got cpu_rst=%b cpu_ce=%b done=%b cycle_cnt=%0d, want cpu_rst=%b cpu_ce=%b done=%b cycle_cnt=%0d",
                     nm, $time, r, c, d, cnt, e.r, e.c, e.d, e.cnt);
        end
    endtask

    // Monitor: outputs are sampled mid-cycle, away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (qa.size() > 0) begin
                e = qa.pop_front();
                chk("dut_a", e, cpu_rst_a, cpu_ce_a, done_a, longint'({32'd0, cnt_a}));
            end
            while (qb.size() > 0) begin
                e = qb.pop_front();
                chk("dut_b", e, cpu_rst_b, cpu_ce_b, done_b, longint'({60'd0, cnt_b}));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            ma = mdl_edge(ma, sw_a, halt_a, 4, 50);
            mb = mdl_edge(mb, sw_b, halt_b, 1, 0);
        end
        qa.push_back(exp_of(ma, MAXA));
        qb.push_back(exp_of(mb, MAXB));
        #1;
    endtask

    // Pulls rst low between edges; the pending expectation for this cycle is
    // replaced with reset values, so the next sample checks the async clear.
    task automatic async_rst();
        #1;
        rst = 1'b0;
        ma  = mdl_reset();
        mb  = mdl_reset();
        if (qa.size() > 0) qa[qa.size()-1] = exp_of(ma, MAXA);
        else               qa.push_back(exp_of(ma, MAXA));
        if (qb.size() > 0) qb[qb.size()-1] = exp_of(mb, MAXB);
        else               qb.push_back(exp_of(mb, MAXB));
        tick();
        rst = 1'b1;
    endtask

    task automatic run_until(input int target);
        int n;
        n = 0;
        while (!(ma.phase == P_RUN && ma.run == target) && n < 300) begin
            tick();
            n++;
        end
        tests++;
        if (n >= 300) begin
            fails++;
            $display("FAIL wait_run: cycle count %0d, required %0d", ma.run, target);
        end
    endtask

    initial begin
        ma = mdl_reset();
        mb = mdl_reset();
        #2;
        qa.push_back(exp_of(ma, MAXA));
        qb.push_back(exp_of(mb, MAXB));
        repeat (2) tick();
        rst = 1'b1;

        // Power-on: full 50-cycle run on A, B saturates at 15 and stays in RUN.
        repeat (70) tick();

        // Soft reset held 3 cycles in DONE, then a halt at cycle 10 (B halts too).
        sw_a = 1'b1;
        repeat (3) tick();
        sw_a = 1'b0;
        run_until(10);
        halt_a = 1'b1;
        halt_b = 1'b1;
        tick();
        halt_a = 1'b0;
        halt_b = 1'b0;
        repeat (5) tick();

        // Halt coinciding with the run limit.
        sw_a = 1'b1;
        sw_b = 1'b1;
        tick();
        sw_a = 1'b0;
        sw_b = 1'b0;
        run_until(49);
        halt_a = 1'b1;
        tick();
        halt_a = 1'b0;
        repeat (5) tick();

        // Soft reset and halt together: soft reset wins.
        sw_a = 1'b1;
        tick();
        sw_a = 1'b0;
        run_until(5);
        sw_a   = 1'b1;
        halt_a = 1'b1;
        tick();
        sw_a   = 1'b0;
        halt_a = 1'b0;
        repeat (8) tick();

        // Async reset mid-run, then the full sequence again.
        run_until(20);
        async_rst();
        repeat (70) tick();

        for (int i = 0; i < 600; i++) begin
            sw_a   = ($urandom_range(15) == 0);
            halt_a = ($urandom_range(7) == 0);
            sw_b   = ($urandom_range(31) == 0);
            halt_b = ($urandom_range(15) == 0);
            if ($urandom_range(199) == 0) async_rst();
            else tick();
        end

        sw_a   = 1'b0;
        halt_a = 1'b0;
        sw_b   = 1'b0;
        halt_b = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
